spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_clk_gen.sv | 42 ++++
 rtl/spi_master_multi.sv | 112 +++++++++++
 tb/tb_spi_master_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM states, mode bit indices and counter width helper for spi_master_multi
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  function automatic int hc_w(input int dw);
    return $clog2(2 * dw);
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter, sck generation and leading/trailing edge strobes
module spi_clk_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             tog_en,
  input  logic             idle_pol,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             tick,
  output logic             tick_next,
  output logic             lead_edge,
  output logic             trail_edge
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic sck_q, sck_d, toggle;
  always_comb begin
    tick = en && cnt_q == '0;
    tick_next = en && (tick ? div_q == '0 : cnt_q == DIV_W'(1));
    toggle = tick && tog_en;
    lead_edge = toggle && sck_q == cpol;
    trail_edge = toggle && sck_q != cpol;
    div_d = load ? div : div_q;
    cnt_d = load ? div : !en ? '0 : tick ? div_q : cnt_q - DIV_W'(1);
    sck_d = en ? sck_q ^ toggle : idle_pol;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      sck_q <= sck_d;
    end
  assign sck = sck_q;
endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with CPOL/CPHA modes and CS_NUM chip selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first port (otherwise MSB first).
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CS_NUM = 4,
  parameter int DIV_W = 16,
  localparam int CSW = CS_NUM > 1 ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [CS_NUM-1:0] cs_n
);
  localparam int HW = hc_w(DATA_W);
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [CSW-1:0] cs_q, cs_d;
  logic lsb_in, lsb_q, lsb_d, lsb;
  logic [DATA_W-1:0] tx_q, tx_d, tx_src, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [CS_NUM-1:0] cs_n_q, cs_n_d;
  logic mosi_q, mosi_d, rx_valid_q, rx_valid_d;
  logic accept, last_hp, tick, tick_next, lead_edge, trail_edge, out_ev, in_ev;
`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif
  spi_clk_gen #(.DIV_W(DIV_W)) u_clk (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .en         (state_q != IDLE),
    .tog_en     (state_q == SETUP || (state_q == SHIFT && !last_hp)),
    .idle_pol   (mode[CPOL_BIT]),
    .cpol       (mode_q[CPOL_BIT]),
    .div        (clk_div),
    .sck        (sck),
    .tick       (tick),
    .tick_next  (tick_next),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );
  always_comb begin
    accept = start && state_q == IDLE;
    last_hp = hcnt_q == HW'(2 * DATA_W - 1);
    state_d = accept ? SETUP : !tick ? state_q : state_q == SETUP ? SHIFT :
              state_q == HOLD ? IDLE : (state_q == SHIFT && last_hp) ? HOLD : state_q;
    hcnt_d = state_q == SHIFT ? hcnt_q + HW'(tick) : '0;
    mode_d = accept ? mode : mode_q;
    cs_d = accept ? cs_sel : cs_q;
    lsb_d = accept ? lsb_in : lsb_q;
    lsb = accept ? lsb_in : lsb_q;
    // CPHA=0 presents the first bit at acceptance, so SETUP already carries it
    out_ev = accept ? !mode[CPHA_BIT] : mode_q[CPHA_BIT] ? lead_edge : trail_edge;
    in_ev = mode_q[CPHA_BIT] ? trail_edge : lead_edge;
    tx_src = accept ? tx_data : tx_q;
    tx_d = !out_ev ? tx_src : lsb ? tx_src >> 1 : tx_src << 1;
    mosi_d = state_d == IDLE ? 1'b0 : out_ev ? (lsb ? tx_src[0] : tx_src[DATA_W-1]) : mosi_q;
    rx_sh_d = accept ? '0 : !in_ev ? rx_sh_q :
              lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
    rx_valid_d = state_d == HOLD && tick_next;
    rx_data_d = rx_valid_d ? rx_sh_q : rx_data_q;
    for (int i = 0; i < CS_NUM; i++) cs_n_d[i] = state_d == IDLE || cs_d != CSW'(i);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      cs_q <= '0;
      lsb_q <= 1'b0;
      tx_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      hcnt_q <= '0;
      mosi_q <= 1'b0;
      cs_n_q <= '1;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cs_q <= cs_d;
      lsb_q <= lsb_d;
      tx_q <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      hcnt_q <= hcnt_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
    end
  assign ready = state_q == IDLE;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed checks of spi_master_multi (4 chip selects, plus a 5-select copy for out-of-range decode)
module tb_spi_master_multi;
  logic clk, rst, start, miso, use_slave;
  logic [1:0] mode;
  logic [15:0] clk_div;
  logic [2:0] sel3;
  logic [7:0] tx_data, rx_data, rx5, s_tx;
  logic ready, rx_valid, sck, mosi, ready5, rv5, sck5, mosi5;
  logic [3:0] cs_n;
  logic [4:0] cs5;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first;
`endif
  int total = 0, bad = 0;
  int f_lat, f_val, f_pul, f_pul5;
  logic f_mosi1, f_cs_ok, f_cs5_ok;
  logic [3:0] f_cs;
  logic [4:0] f_cs5;
  logic [7:0] f_rx, f_rx5;
  int s_lead = 0, s_trail = 0, s_k;
  logic s_prev = 1'b0, s_bit;

  spi_master_multi #(.DATA_W(8), .CS_NUM(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .mode(mode), .clk_div(clk_div),
    .cs_sel(sel3[1:0]), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .sck(sck), .mosi(mosi), .miso(miso),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs_n));

  spi_master_multi #(.DATA_W(8), .CS_NUM(5), .DIV_W(16)) dut5 (
    .clk(clk), .rst(rst), .start(start), .ready(ready5), .mode(mode), .clk_div(clk_div),
    .cs_sel(sel3), .tx_data(tx_data), .rx_data(rx5), .rx_valid(rv5),
    .sck(sck5), .mosi(mosi5), .miso(mosi5),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave: counts sck edges within a frame and presents s_tx MSB first on its own shift edge
  always @(sck or cs_n) begin
    if (&cs_n) begin
      s_lead = 0;
      s_trail = 0;
    end else if (sck !== s_prev) begin
      if (sck !== mode[1]) s_lead++;
      else s_trail++;
    end
    s_prev = sck;
  end
  always_comb begin
    s_k = mode[0] ? s_lead - 1 : s_trail;
    s_bit = (s_k >= 0 && s_k < 8) ? s_tx[7 - s_k] : 1'b0;
    miso = use_slave ? s_bit : mosi;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [7:0] d);
    logic [2:0] sv;
    logic [15:0] dv;
    logic p, p5;
    sv = sel3;
    dv = clk_div;
    tx_data = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tx_data = ~d;
    sel3 = sv ^ 3'd1;
    clk_div = dv + 16'd3;
    f_lat = 1; f_val = 0; f_pul = 0; f_pul5 = 0;
    f_mosi1 = mosi; f_cs = cs_n; f_cs5 = cs5; f_cs_ok = 1'b1; f_cs5_ok = 1'b1;
    p = sck; p5 = sck5;
    while (ready !== 1'b1 && f_lat < 400) begin
      f_val += int'(rx_valid);
      if (sck !== p && sck !== mode[1]) f_pul++;
      if (sck5 !== p5 && sck5 !== mode[1]) f_pul5++;
      p = sck; p5 = sck5;
      if (cs_n !== f_cs) f_cs_ok = 1'b0;
      if (cs5 !== f_cs5) f_cs5_ok = 1'b0;
      @(posedge clk); #1;
      f_lat++;
    end
    f_rx = rx_data;
    f_rx5 = rx5;
    sel3 = sv;
    clk_div = dv;
  endtask

  initial begin
    int n, w;
    logic p;
    rst = 1'b1; start = 1'b0; mode = 2'b00; clk_div = 16'd1; sel3 = 3'd2;
    tx_data = 8'h00; use_slave = 1'b0; s_tx = 8'h00;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mode = 2'b10;
    chk("idle_sck_before", sck, 0);
    @(posedge clk); #1;
    chk("idle_sck_follow", sck, 1);
    mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    // mode 0 loopback, clk_div=1
    frame(8'hA5);
    chk("t1_latency", f_lat, 37);
    chk("t1_rx", f_rx, 8'hA5);
    chk("t1_valid_pulses", f_val, 1);
    chk("t1_sck_pulses", f_pul, 8);
    chk("t1_first_mosi", f_mosi1, 1);
    chk("t1_cs_n", f_cs, 4'b1011);
    chk("t1_cs_steady", f_cs_ok, 1);
    // all four modes against the slave model
    use_slave = 1'b1;
    s_tx = 8'hC3;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("t2_idle_sck_m%0d", m), sck, mode[1]);
      frame(8'h3C);
      chk($sformatf("t2_rx_m%0d", m), f_rx, 8'hC3);
      chk($sformatf("t2_valid_m%0d", m), f_val, 1);
      chk($sformatf("t2_pulses_m%0d", m), f_pul, 8);
      chk($sformatf("t2_latency_m%0d", m), f_lat, 37);
    end
    use_slave = 1'b0;
    mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    // chip-select decode, in range and out of range
    sel3 = 3'd2;
    frame(8'h5A);
    chk("t3_cs_n", f_cs, 4'b1011);
    chk("t3_cs5", f_cs5, 5'b11011);
    chk("t3_cs5_steady", f_cs5_ok, 1);
    sel3 = 3'd5;
    frame(8'h69);
    chk("t3_oor_cs5", f_cs5, 5'h1F);
    chk("t3_oor_steady", f_cs5_ok, 1);
    chk("t3_oor_pulses", f_pul5, 8);
    chk("t3_oor_rx", f_rx5, 8'h69);
    sel3 = 3'd2;
    // reset after the 3rd sck pulse
    tx_data = 8'hF0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; w = 0; p = sck;
    while (n < 3 && w < 100) begin
      @(posedge clk); #1;
      w++;
      if (sck === 1'b1 && p === 1'b0) n++;
      p = sck;
    end
    chk("t4_three_pulses", n, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_cs_n", cs_n, 4'hF);
    chk("t4_sck", sck, 0);
    chk("t4_ready", ready, 1);
    chk("t4_rx_valid", rx_valid, 0);
    chk("t4_rx_data", rx_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_no_valid", rx_valid, 0);
    end
    frame(8'h96);
    chk("t4_after_rx", f_rx, 8'h96);
    chk("t4_after_latency", f_lat, 37);
    // start held high, clk_div=0
    clk_div = 16'd0;
    tx_data = 8'hA5;
    start = 1'b1;
    for (int i = 1; i <= 57; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_ready_%0d", i), ready, (i % 19) == 0);
      chk($sformatf("t5_cs_n_%0d", i), cs_n, (i % 19) == 0 ? 4'hF : 4'b1011);
      chk($sformatf("t5_valid_%0d", i), rx_valid, (i % 19) == 18);
    end
    start = 1'b0;
    chk("t5_rx", rx_data, 8'hA5);
    clk_div = 16'd1;
    repeat (2) @(posedge clk);
    #1;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    frame(8'h01);
    chk("t6_first_mosi", f_mosi1, 1);
    chk("t6_rx", f_rx, 8'h01);
    lsb_first = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
